uart_tx_mmio: RTL and testbench
===============================

Name: uart_tx_mmio

Overview:
- Memory-mapped UART transmitter on the data-memory bus of the single-cycle RISC-V core; consumes the core's store traffic (ALU result as address, rs2 data as write data, MemWrite).
- Buffers bytes in a small FIFO and serializes them as 8N1 frames on a TX pin.
- Exposes a status word that the core reads through the existing load-result path, selected by `Hit`.

Parameters:
- DATA_WIDTH, 32, bus data/address width.
- BASE_ADDR, 32'h1001_0000, register block base address; 8-byte aligned.
- CLKS_PER_BIT, 434, clock cycles per serial bit; must be ≥ 2.
- FIFO_DEPTH, 8, TX FIFO entries; power of two, ≥ 2.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- Address  in  DATA_WIDTH  byte address from the core's ALU result.
- WriteData  in  DATA_WIDTH  store data; only bits [7:0] are used.
- MemWrite  in  1  store strobe, sampled at the rising edge.
- ReadData  out  DATA_WIDTH  combinational register read data.
- Hit  out  1  combinational; 1 when Address[31:3] == BASE_ADDR[31:3].
- tx  out  1  registered serial output; idle high.

Behaviour:
- Register map:
  - offset 0x0 TX_DATA: write-only; reads return 0.
  - offset 0x4 STATUS: read returns {16'b0, count[7:0], 4'b0, ovf, empty, full, busy}.
  - Offsets 0x1–0x3 and 0x5–0x7 read 0 and ignore writes. Addresses outside the block give Hit=0 and ReadData=0.
- Push: MemWrite && Hit && offset 0x0 && !full writes WriteData[7:0] at the edge.
- Overflow: the same write while full drops the byte and sets the sticky `ovf` flag.
- Clearing ovf: MemWrite to offset 0x4 clears ovf. If an overflowing push and this clear occur together, set wins. (A single address cannot do both, so this applies only if a future multi-port bus is added.)
- `full`, `empty` and `count` reflect the state before the edge.
- Push on a full FIFO is rejected even if a pop occurs in the same cycle.
- Simultaneous push and pop on a non-full FIFO leaves count unchanged.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: tx=1. If !empty, pop at the edge, load the shift register, go to START.
  - START: tx=0 for CLKS_PER_BIT cycles, then DATA.
  - DATA: 8 bits, LSB first, each held CLKS_PER_BIT cycles. A bit index of 0..7 advances on each baud tick.
  - STOP: tx=1 for CLKS_PER_BIT cycles. At the final stop cycle, if !empty, pop and go directly to START (back-to-back frames, no idle gap); otherwise go to IDLE.
- Baud counter: counts 0..CLKS_PER_BIT-1 and resets to 0 on every state entry.
- Frame length: exactly 10×CLKS_PER_BIT cycles.
- Latency: a push at edge E0 gives tx=0 starting from edge E1 (first pop at E1).
- busy = (state != IDLE).
- Reset (synchronous, any time, including mid-frame):
  - state=IDLE, tx=1 after the edge.
  - FIFO pointers and count = 0 (FIFO flushed); ovf=0; baud counter and bit index = 0.
  - ReadData and Hit stay combinational. After reset, STATUS reads 0x0000_0004.
- Pointers: wrap modulo FIFO_DEPTH. count is one bit wider than the pointer width and is zero-extended to 8 bits in STATUS.

Optional Feature:
- UART_TX_PARITY_EN defined:
  - Adds a PARITY state between DATA and STOP that drives the even parity bit (XOR of the 8 data bits) for CLKS_PER_BIT cycles.
  - Frame is 11×CLKS_PER_BIT cycles.
  - STATUS bit 4 reads 1 (capability flag).
- Not defined: no PARITY state, 10-bit frames, STATUS bit 4 reads 0.

Test Plan:
- Reset with CLKS_PER_BIT=4, FIFO_DEPTH=8:
  - Assert reset 2 cycles → tx=1.
  - Read 0x1001_0004 → ReadData=0x0000_0004, Hit=1.
  - Read 0x1001_0010 → Hit=0, ReadData=0.
- Single byte: store 0x0000_00A5 to 0x1001_0000.
  - tx=0 for cycles 1–4 after the write edge.
  - Then bits 1,0,1,0,0,1,0,1 for 4 cycles each, then stop high for 4 cycles.
  - busy=1 during the 40-cycle frame, 0 afterwards.
- Back-to-back: store 0x55 then 0x0F on consecutive cycles.
  - The second start bit begins on the cycle immediately after the first frame's 4th stop cycle; no idle gap.
  - count reads 1 during frame 1.
- Overflow: store 10 bytes in 10 consecutive cycles while tx is busy.
  - First pop at cycle 1, then 8 pushed → full=1, count=8.
  - The 10th write sets ovf; STATUS = 0x0000_080B.
  - Store to 0x1001_0004 → ovf=0.
- Mid-frame reset: assert reset during DATA bit 3 of a frame with 3 bytes queued.
  - tx=1 after the reset edge, STATUS=0x0000_0004.
  - No further frames are sent.
- UART_TX_PARITY_EN: store 0x07.
  - Parity bit 1 is driven after bit 7; frame is 44 cycles; STATUS bit 4 = 1.

Source files
------------

// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter with a small TX FIFO on the core's data bus.
// Define UART_TX_PARITY_EN to add an even-parity bit (11-bit frames, STATUS[4] = 1).
module uart_tx_mmio #(
  parameter int                    DATA_WIDTH   = 32,
  parameter logic [DATA_WIDTH-1:0] BASE_ADDR    = 32'h1001_0000,
  parameter int                    CLKS_PER_BIT = 434,
  parameter int                    FIFO_DEPTH   = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] Address,
  input  logic [DATA_WIDTH-1:0] WriteData,
  input  logic                  MemWrite,
  output logic [DATA_WIDTH-1:0] ReadData,
  output logic                  Hit,
  output logic                  tx
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int BW = $clog2(CLKS_PER_BIT);
`ifdef UART_TX_PARITY_EN
  localparam logic PARITY_CAP = 1'b1;
`else
  localparam logic PARITY_CAP = 1'b0;
`endif

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_e;

  state_e          state_q, state_d;
  logic [BW-1:0]   baud_q, baud_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic            par_q, par_d;
  logic            tx_q, tx_d;

  logic [7:0]      mem [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]   count_q, count_d;
  logic            ovf_q, ovf_d;

  logic [2:0]      off;
  logic            full, empty, busy, tick, push, pop, ovf_set, ovf_clr;
  logic [7:0]      fifo_rd;
  logic [31:0]     status;
  logic            unused_wdata;

  assign unused_wdata = ^WriteData[DATA_WIDTH-1:8];

  // Register decode
  assign off     = Address[2:0];
  assign Hit     = (Address[DATA_WIDTH-1:3] == BASE_ADDR[DATA_WIDTH-1:3]);
  assign full    = (count_q == CW'(FIFO_DEPTH));
  assign empty   = (count_q == '0);
  assign busy    = (state_q != S_IDLE);
  assign push    = MemWrite && Hit && (off == 3'd0) && !full;
  assign ovf_set = MemWrite && Hit && (off == 3'd0) && full;
  assign ovf_clr = MemWrite && Hit && (off == 3'd4);
  assign status  = {16'b0, 8'(count_q), 3'b0, PARITY_CAP, ovf_q, empty, full, busy};
  assign ReadData = (Hit && off == 3'd4) ? DATA_WIDTH'(status) : '0;

  assign tick    = (baud_q == BW'(CLKS_PER_BIT - 1));
  assign pop     = !empty && ((state_q == S_IDLE) || (state_q == S_STOP && tick));
  assign fifo_rd = mem[rd_ptr_q];
  assign tx      = tx_q;

  // TX FIFO
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= WriteData[7:0];
  end

  always_comb begin
    count_d = count_q;
    if (push && !pop)      count_d = count_q + CW'(1);
    else if (pop && !push) count_d = count_q - CW'(1);
    ovf_d = ovf_q;
    if (ovf_clr) ovf_d = 1'b0;
    if (ovf_set) ovf_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
    end
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    par_d   = par_q;
    bit_d   = bit_q;
    baud_d  = baud_q;
    case (state_q)
      S_IDLE:   if (pop) state_d = S_START;
      S_START:  if (tick) state_d = S_DATA;
      S_DATA: begin
        if (tick) begin
          if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end else begin
            bit_d   = bit_q + 3'd1;
            shift_d = shift_q >> 1;
          end
        end
      end
      S_PARITY: if (tick) state_d = S_STOP;
      S_STOP:   if (tick) state_d = pop ? S_START : S_IDLE;
      default:  state_d = S_IDLE;
    endcase
    if (pop) begin
      shift_d = fifo_rd;
      par_d   = ^fifo_rd;
    end
    // Baud counter and bit index restart on every state entry
    if (state_d != state_q) begin
      baud_d = '0;
      bit_d  = '0;
    end else begin
      baud_d = tick ? '0 : baud_q + 1'b1;
    end
  end

  // FSM output (registered TX pin follows the next state)
  always_comb begin
    tx_d = 1'b1;
    case (state_d)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = shift_d[0];
      S_PARITY: tx_d = par_q;
      default:  tx_d = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Scoreboard bench for uart_tx_mmio: stimulus queues expected tx/busy per cycle and
// expected register reads; a negedge monitor pops and compares.
module tb_uart_tx_mmio;
  localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
  localparam logic [31:0] CAP = 32'h10;
`else
  localparam int NB = 10;
  localparam logic [31:0] CAP = 32'h0;
`endif
  localparam logic [31:0] BASE = 32'h1001_0000;
  localparam logic [31:0] STAT = 32'h1001_0004;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] Address, WriteData, ReadData;
  logic        MemWrite, Hit, tx;
  logic        rd_en;

  logic [1:0]  txq [$];
  logic [32:0] rdq [$];
  int n_chk = 0, n_pass = 0, n_tmo = 0;

  uart_tx_mmio #(.DATA_WIDTH(32), .BASE_ADDR(32'h1001_0000), .CLKS_PER_BIT(CPB), .FIFO_DEPTH(8)) dut (
    .clk(clk), .reset(reset), .Address(Address), .WriteData(WriteData),
    .MemWrite(MemWrite), .ReadData(ReadData), .Hit(Hit), .tx(tx));

  always #5 clk = ~clk;

  // Monitor
  always @(negedge clk) begin
    logic [1:0]  et;
    logic [32:0] er;
    if (rd_en && rdq.size() > 0) begin
      er = rdq.pop_front();
      n_chk++;
      if ({Hit, ReadData} === er) n_pass++;
      else $display("FAIL read addr=%h got hit=%b data=%h exp hit=%b data=%h",
                    Address, Hit, ReadData, er[32], er[31:0]);
    end
    if (txq.size() > 0) begin
      et = txq.pop_front();
      n_chk++;
      if ({tx, dut.busy} === et) n_pass++;
      else $display("FAIL tx_busy t=%0t got tx=%b busy=%b exp tx=%b busy=%b",
                    $time, tx, dut.busy, et[1], et[0]);
    end
  end

  function automatic logic fbit(input logic [7:0] b, input int i);
    if (i == 0) return 1'b0;
    if (i <= 8) return b[i-1];
    if (NB == 11 && i == 9) return ^b;
    return 1'b1;
  endfunction

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_idle(input int n);
    for (int i = 0; i < n; i++) txq.push_back(2'b10);
  endtask

  task automatic push_frame(input logic [7:0] b, input int n);
    for (int k = 0; k < n; k++) txq.push_back({fbit(b, k / CPB), 1'b1});
  endtask

  task automatic rd(input logic [31:0] a, input logic h, input logic [31:0] d);
    Address  = a;
    MemWrite = 1'b0;
    rdq.push_back({h, d});
    rd_en = 1'b1;
    cyc(1);
    rd_en = 1'b0;
  endtask

  task automatic wait_drain();
    int t = 0;
    while ((txq.size() > 0 || rdq.size() > 0) && t < 5000) begin
      cyc(1);
      t++;
    end
    if (t >= 5000) begin
      $display("FAIL drain_timeout queue=%0d exp 0", txq.size());
      n_tmo++;
    end
  endtask

  initial begin
    reset = 1'b1; MemWrite = 1'b0; Address = '0; WriteData = '0; rd_en = 1'b0;
    cyc(2);
    reset = 1'b0;
    // Reset state and decode
    push_idle(3);
    rd(STAT, 1'b1, 32'h4 | CAP);
    rd(32'h1001_0010, 1'b0, 32'h0);
    rd(BASE, 1'b1, 32'h0);
    rd(32'h1001_0006, 1'b1, 32'h0);
    wait_drain();

    // Single byte
    Address = BASE; WriteData = 32'hA5; MemWrite = 1'b1;
    cyc(1);
    MemWrite = 1'b0;
    push_idle(1); push_frame(8'hA5, NB * CPB); push_idle(4);
    wait_drain();

    // Back-to-back frames
    Address = BASE; WriteData = 32'h55; MemWrite = 1'b1;
    cyc(1);
    WriteData = 32'h0F;
    push_idle(1); push_frame(8'h55, NB * CPB); push_frame(8'h0F, NB * CPB); push_idle(4);
    cyc(1);
    MemWrite = 1'b0;
    rd(STAT, 1'b1, 32'h0000_0101 | CAP);
    wait_drain();

    // Overflow
    for (int i = 0; i < 10; i++) begin
      Address = BASE; WriteData = 32'hA0 + i; MemWrite = 1'b1;
      cyc(1);
      if (i == 0) begin
        push_idle(1);
        for (int j = 0; j < 9; j++) push_frame(8'hA0 + 8'(j), NB * CPB);
        push_idle(4);
      end
    end
    MemWrite = 1'b0;
    rd(STAT, 1'b1, 32'h0000_080B | CAP);
    Address = STAT; WriteData = 32'h0; MemWrite = 1'b1;
    cyc(1);
    MemWrite = 1'b0;
    rd(STAT, 1'b1, 32'h0000_0803 | CAP);
    wait_drain();

    // Mid-frame reset during data bit 3
    for (int i = 0; i < 3; i++) begin
      Address = BASE; WriteData = 32'h11 * (i + 1); MemWrite = 1'b1;
      cyc(1);
      if (i == 0) begin
        push_idle(1); push_frame(8'h11, 17);
      end
    end
    MemWrite = 1'b0;
    cyc(15);
    reset = 1'b1;
    cyc(1);
    reset = 1'b0;
    push_idle(40);
    rd(STAT, 1'b1, 32'h4 | CAP);
    wait_drain();

    // Parity-sensitive byte
    Address = BASE; WriteData = 32'h07; MemWrite = 1'b1;
    cyc(1);
    MemWrite = 1'b0;
    push_idle(1); push_frame(8'h07, NB * CPB); push_idle(4);
    wait_drain();
    rd(STAT, 1'b1, 32'h4 | CAP);
    cyc(2);

    $display("%0d/%0d checks passed", n_pass, n_chk + n_tmo);
    $finish;
  end
endmodule
